// File: rtl/pong_pkg.sv
// Shared Pong timing constants and the frame scheduler state encoding.
package pong_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int H_TOTAL  = 800;
  localparam int V_TOTAL  = 525;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    NEXT = 2'd3
  } sched_state_t;

endpackage

// File: rtl/frame_event_detect.sv
// Scan-position strobes for blanking/active start and the frame divider.
module frame_event_detect #(
  parameter int V_ACTIVE  = pong_pkg::V_ACTIVE,
  parameter int FRAME_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pixel_tick,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       enable,
  output logic       fev,
  output logic       aev,
  output logic       launch
);

  logic [7:0] div;
  logic       line_start;
  logic       div_hit;

  // x==0 spans several clocks; the tick makes each strobe one clock wide
  assign line_start = pixel_tick && (pixel_x == 10'd0);
  assign fev        = line_start && (pixel_y == 10'(V_ACTIVE));
  assign aev        = line_start && (pixel_y == 10'd0);
  assign div_hit    = (div == 8'(FRAME_DIV - 1));
  assign launch     = fev && enable && div_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
    end else if (fev && enable) begin
      div <= div_hit ? 8'd0 : div + 8'd1;
    end
  end

endmodule

// File: rtl/frame_update_scheduler.sv
// Once-per-frame req/ack sequencer that updates game objects during
// vertical blanking, with timeout and overrun flags.
module frame_update_scheduler #(
  parameter int N_OBJ     = 3,
  parameter int V_ACTIVE  = pong_pkg::V_ACTIVE,
  parameter int TIMEOUT   = 1023,
  parameter int FRAME_DIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pixel_tick,
  input  logic [9:0]       pixel_x,
  input  logic [9:0]       pixel_y,
  input  logic             enable,
  input  logic             clr_err,
  input  logic [N_OBJ-1:0] upd_ack,
  output logic [N_OBJ-1:0] upd_req,
  output logic             upd_busy,
  output logic             frame_done,
  output logic [15:0]      frame_cnt,
  output logic             timeout_err,
  output logic             overrun
);

  import pong_pkg::*;

  localparam int IW = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  sched_state_t  state;
  logic [IW-1:0] idx;
  logic [TW-1:0] tcnt;
  logic          fev;
  logic          aev;
  logic          launch;
  logic          last;

  assign last = (idx == IW'(N_OBJ - 1));

  frame_event_detect #(
    .V_ACTIVE  (V_ACTIVE),
    .FRAME_DIV (FRAME_DIV)
  ) u_fed (
    .clk        (clk),
    .rst        (rst),
    .pixel_tick (pixel_tick),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .enable     (enable),
    .fev        (fev),
    .aev        (aev),
    .launch     (launch)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (fev && enable) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

  // tcnt counts every cycle the current req is high, REQ included
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      tcnt        <= '0;
      upd_req     <= '0;
      upd_busy    <= 1'b0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (clr_err) begin
        timeout_err <= 1'b0;
        overrun     <= 1'b0;
      end
      if (aev && state != IDLE) begin
        overrun  <= 1'b1;
        upd_req  <= '0;
        upd_busy <= 1'b0;
        tcnt     <= '0;
        state    <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (launch) begin
              idx      <= '0;
              upd_req  <= N_OBJ'(1);
              upd_busy <= 1'b1;
              state    <= REQ;
            end
          end
          REQ: begin
            tcnt  <= tcnt + TW'(1);
            state <= WAIT;
          end
          WAIT: begin
            if (upd_ack[idx]) begin
              upd_req <= '0;
              state   <= NEXT;
            end else if (tcnt >= TW'(TIMEOUT - 1)) begin
              timeout_err <= 1'b1;
              upd_req     <= '0;
              state       <= NEXT;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
          NEXT: begin
            tcnt <= '0;
            if (last) begin
              frame_done <= 1'b1;
              upd_busy   <= 1'b0;
              state      <= IDLE;
            end else begin
              idx     <= idx + IW'(1);
              upd_req <= N_OBJ'(1) << (idx + IW'(1));
              state   <= REQ;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Bench for frame_update_scheduler: table rows, hand-written corner
// sequences and random ack latencies against a transaction-level model.
module tb_frame_update_scheduler;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        pixel_tick;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        enable;
  logic        clr_err;
  logic [2:0]  upd_ack;
  logic [2:0]  upd_req;
  logic        upd_busy;
  logic        frame_done;
  logic [15:0] frame_cnt;
  logic        timeout_err;
  logic        overrun;

  logic [2:0]  ack3;
  logic [2:0]  req3;
  logic        busy3;
  logic        done3;
  logic [15:0] cnt3;
  logic        terr3;
  logic        ovr3;

  typedef struct {
    int idx;
    int start;
    int dur;
  } pulse_t;

  typedef struct {
    int d0, d1, d2;
    int e0, e1, e2;
    int err;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fev_cyc = 0;
  int dones = 0;
  int dones3 = 0;
  int err_cycles = 0;
  int fcnt_exp = 0;
  int noise = 0;
  int dly[3];
  int hc[3];
  int st[3];
  pulse_t pq[$];
  vec_t tbl[6];

  always #5 clk = ~clk;

  frame_update_scheduler #(
    .N_OBJ(3), .V_ACTIVE(480), .TIMEOUT(TO), .FRAME_DIV(1)
  ) dut (
    .clk(clk), .rst(rst), .pixel_tick(pixel_tick),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .enable(enable),
    .clr_err(clr_err), .upd_ack(upd_ack), .upd_req(upd_req),
    .upd_busy(upd_busy), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .timeout_err(timeout_err),
    .overrun(overrun)
  );

  frame_update_scheduler #(
    .N_OBJ(3), .V_ACTIVE(480), .TIMEOUT(TO), .FRAME_DIV(3)
  ) dut3 (
    .clk(clk), .rst(rst), .pixel_tick(pixel_tick),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .enable(enable),
    .clr_err(clr_err), .upd_ack(ack3), .upd_req(req3),
    .upd_busy(busy3), .frame_done(done3),
    .frame_cnt(cnt3), .timeout_err(terr3),
    .overrun(ovr3)
  );

  function automatic int exp_dur(int d);
    if (d > TO) return TO;
    if (d < 2) return 2;
    return d;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // one clock; client models respond to what they see after the edge
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (frame_done) dones++;
    if (done3) dones3++;
    if (timeout_err) err_cycles++;
    check("onehot", int'($countones(upd_req) <= 1), 1);
    for (int i = 0; i < 3; i++) begin
      if (upd_req[i]) begin
        if (hc[i] == 0) st[i] = cyc;
        hc[i]++;
      end else if (hc[i] > 0) begin
        pq.push_back('{i, st[i], hc[i]});
        hc[i] = 0;
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (upd_req[i]) upd_ack[i] = (hc[i] >= dly[i]);
      else upd_ack[i] = (noise != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    ack3 = req3;
  endtask

  task automatic line(int y);
    pixel_x = 10'd0;
    pixel_y = 10'(y);
    pixel_tick = 1'b1;
    if (y == 480 && enable) fcnt_exp++;
    fev_cyc = cyc;
    step();
    pixel_tick = 1'b0;
    repeat (3) step();
    pixel_x = 10'd1;
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while (upd_busy && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) check("idle_budget", n, 0);
  endtask

  task automatic run_frame(int d0, int d1, int d2);
    dly = '{d0, d1, d2};
    pq.delete();
    dones = 0;
    err_cycles = 0;
    line(480);
    wait_idle(200);
  endtask

  task automatic check_frame(string tag, int e0, int e1, int e2, int eerr);
    int e[3];
    e = '{e0, e1, e2};
    check({tag, "_npulse"}, pq.size(), 3);
    if (pq.size() == 3) begin
      check({tag, "_start0"}, pq[0].start, fev_cyc + 1);
      for (int k = 0; k < 3; k++) begin
        check($sformatf("%s_idx%0d", tag, k), pq[k].idx, k);
        check($sformatf("%s_dur%0d", tag, k), pq[k].dur, e[k]);
        if (k > 0)
          check($sformatf("%s_gap%0d", tag, k), pq[k].start,
                pq[k-1].start + pq[k-1].dur + 1);
      end
    end
    check({tag, "_done"}, dones, 1);
    check({tag, "_terr"}, int'(timeout_err), eerr);
    check({tag, "_fcnt"}, int'(frame_cnt), fcnt_exp);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check({tag, "_clr"}, int'(timeout_err), 0);
  endtask

  initial begin
    int n;
    int d[3];
    int eerr;

    tbl[0] = '{2, 2, 2, 2, 2, 2, 0};
    tbl[1] = '{1, 3, 7, 2, 3, 7, 0};
    tbl[2] = '{16, 5, 2, 16, 5, 2, 0};
    tbl[3] = '{17, 2, 2, 16, 2, 2, 1};
    tbl[4] = '{2, 1000, 2, 2, 16, 2, 1};
    tbl[5] = '{15, 16, 1, 15, 16, 2, 0};

    rst = 1'b1;
    pixel_tick = 1'b0;
    pixel_x = 10'd1;
    pixel_y = 10'd100;
    enable = 1'b1;
    clr_err = 1'b0;
    upd_ack = '0;
    ack3 = '0;
    dly = '{2, 2, 2};
    hc = '{0, 0, 0};
    repeat (3) step();
    check("rst_req", int'(upd_req), 0);
    check("rst_busy", int'(upd_busy), 0);
    check("rst_fcnt", int'(frame_cnt), 0);
    check("rst_flags", int'({timeout_err, overrun, frame_done}), 0);
    rst = 1'b0;
    repeat (2) step();

    // table rows; dut3 divides by 3 and must launch on frames 3 and 6
    dones3 = 0;
    for (int r = 0; r < 6; r++) begin
      run_frame(tbl[r].d0, tbl[r].d1, tbl[r].d2);
      check_frame($sformatf("row%0d", r), tbl[r].e0, tbl[r].e1,
                  tbl[r].e2, tbl[r].err);
      check($sformatf("div3_row%0d", r), dones3, (r + 1) / 3);
    end
    check("div3_cnt", int'(cnt3), 6);

    // error set and clear in the same cycle: set must win for one cycle
    clr_err = 1'b1;
    run_frame(2, 1000, 2);
    clr_err = 1'b0;
    check("prio_errcyc", err_cycles, 1);
    check("prio_done", dones, 1);

    // client 2 stalls until active video restarts
    dly = '{2, 2, 1000};
    pq.delete();
    dones = 0;
    line(480);
    n = 0;
    while (!upd_req[2] && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) check("ovr_req2_budget", n, 0);
    line(480);
    check("ovr_fev_busy_cnt", int'(frame_cnt), fcnt_exp);
    check("ovr_still_busy", int'(upd_busy), 1);
    pixel_x = 10'd0;
    pixel_y = 10'd0;
    pixel_tick = 1'b1;
    step();
    pixel_tick = 1'b0;
    pixel_x = 10'd1;
    check("ovr_flag", int'(overrun), 1);
    check("ovr_req", int'(upd_req), 0);
    check("ovr_busy", int'(upd_busy), 0);
    repeat (3) step();
    check("ovr_nodone", dones, 0);
    check("ovr_npulse", pq.size(), 3);
    check("ovr_noterr", int'(timeout_err), 0);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("ovr_clr", int'(overrun), 0);

    // enable dropped while client 0 waits
    dly = '{8, 2, 2};
    pq.delete();
    dones = 0;
    err_cycles = 0;
    line(480);
    enable = 1'b0;
    wait_idle(200);
    check_frame("en_low", 8, 2, 2, 0);
    pq.delete();
    dones = 0;
    line(480);
    repeat (10) step();
    check("en_fcnt_hold", int'(frame_cnt), fcnt_exp);
    check("en_nolaunch", pq.size(), 0);
    check("en_nodone", dones, 0);
    enable = 1'b1;

    // asynchronous reset while client 1 is requested
    dly = '{2, 1000, 2};
    pq.delete();
    line(480);
    n = 0;
    while (upd_req != 3'b010 && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) check("rst_req1_budget", n, 0);
    step();
    #2 rst = 1'b1;
    #1;
    check("arst_req", int'(upd_req), 0);
    check("arst_busy", int'(upd_busy), 0);
    check("arst_fcnt", int'(frame_cnt), 0);
    check("arst_flags", int'({timeout_err, overrun, frame_done}), 0);
    step();
    rst = 1'b0;
    hc = '{0, 0, 0};
    fcnt_exp = 0;
    step();
    run_frame(2, 2, 2);
    check_frame("post_rst", 2, 2, 2, 0);

    // random ack latencies with noise on the idle ack lines
    noise = 1;
    for (int f = 0; f < 12; f++) begin
      eerr = 0;
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 4) == 0) d[i] = $urandom_range(14, 30);
        else d[i] = $urandom_range(1, 12);
        if (d[i] > TO) eerr = 1;
      end
      run_frame(d[0], d[1], d[2]);
      check_frame($sformatf("rnd%0d", f), exp_dur(d[0]),
                  exp_dur(d[1]), exp_dur(d[2]), eerr);
    end
    noise = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
